// File: rtl/uart_mem_loader.sv
// UART image loader: receives an 8N1 framed download and stores little-endian words to memory.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module uart_mem_loader #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        uart_rx,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [1:0]  length,
  output logic        sign,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] word_count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  logic          rx_s1, rx_s2, rx_prev;
  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic          rx_valid, rx_ferr;

  state_t        state, state_nx;
  logic [7:0]    n_lo;
  logic [15:0]   n_words;
  logic [15:0]   n_full;
  logic [23:0]   word_sr;
  logic [1:0]    byte_idx;
  logic [7:0]    xor_acc;
  logic          timeout;

  assign MemRead  = 1'b0;
  assign length   = 2'b10;
  assign sign     = 1'b0;
  assign MemWrite = (state == S_WRITE);
  assign n_full   = {rx_shift, n_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_nx;
  end

  always_comb begin
    rx_state_nx = rx_state;
    unique case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_state_nx = RX_START;
      RX_START: if (bit_cnt == HALF_M1) rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_cnt == FULL_M1 && bit_idx == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (bit_cnt == FULL_M1) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  // After the half-bit start check, every later sample lands at mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
        end
        RX_START: bit_cnt <= (bit_cnt == HALF_M1) ? '0 : bit_cnt + CW'(1);
        RX_DATA: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_cnt == FULL_M1) begin
            bit_cnt  <= '0;
            rx_valid <= rx_s2;
            rx_ferr  <= !rx_s2;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (rx_valid || !(state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK}))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 32'd1;
  end

  assign timeout = (to_cnt >= TIMEOUT_CYCLES);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if ((state inside {S_HDR, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK}) &&
        (rx_ferr || timeout)) begin
      state_nx = S_ERR;
    end else begin
      unique case (state)
        S_IDLE:   if (start) state_nx = S_HDR;
        S_HDR:    if (rx_valid && rx_shift == 8'hA5) state_nx = S_LEN_LO;
        S_LEN_LO: if (rx_valid) state_nx = S_LEN_HI;
        S_LEN_HI: begin
          if (rx_valid) begin
            if ({16'h0, n_full} > MAX_WORDS) state_nx = S_ERR;
            else if (n_full == 16'd0)        state_nx = S_CHK;
            else                             state_nx = S_DATA;
          end
        end
        S_DATA:   if (rx_valid && byte_idx == 2'd3) state_nx = S_WRITE;
        S_WRITE:  state_nx = (word_count + 16'd1 == n_words) ? S_CHK : S_DATA;
        S_CHK:    if (rx_valid) state_nx = (rx_shift == xor_acc) ? S_DONE : S_ERR;
        S_DONE:   state_nx = S_IDLE;
        S_ERR:    state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr       <= BASE_ADDR;
      din        <= '0;
      word_count <= '0;
      n_lo       <= '0;
      n_words    <= '0;
      word_sr    <= '0;
      byte_idx   <= '0;
      xor_acc    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            addr       <= BASE_ADDR;
            byte_idx   <= '0;
            xor_acc    <= '0;
          end
        end
        S_LEN_LO: if (rx_valid) n_lo <= rx_shift;
        S_LEN_HI: if (rx_valid) n_words <= n_full;
        S_DATA: begin
          if (rx_valid) begin
            word_sr  <= {rx_shift, word_sr[23:8]};
            byte_idx <= byte_idx + 2'd1;
            xor_acc  <= xor_acc ^ rx_shift;
            // din only changes when the completed word is about to be stored
            if (state_nx == S_WRITE) din <= {rx_shift, word_sr};
          end
        end
        S_WRITE: begin
          word_count <= word_count + 16'd1;
          addr       <= addr + 32'd4;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        S_ERR: begin
          err  <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: framed downloads, checksum/length/framing errors, async reset.
module tb_uart_mem_loader;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        uart_rx = 1'b1;
  logic        MemWrite, MemRead, sign, busy, done, err;
  logic [1:0]  length;
  logic [31:0] addr, din;
  logic [15:0] word_count;

  int total = 0;
  int bad = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];

  uart_mem_loader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .uart_rx(uart_rx),
    .MemWrite(MemWrite), .MemRead(MemRead), .length(length), .sign(sign),
    .addr(addr), .din(din), .busy(busy), .done(done), .err(err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (MemWrite) begin
      wr_addr[wr_cnt % 32] = addr;
      wr_data[wr_cnt % 32] = din;
      wr_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] cks, input int bad_stop_idx);
    logic [7:0] f [12];
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    f[11] = cks;
    for (int i = 0; i < 12; i++)
      send_byte(f[i], (i == bad_stop_idx) ? 1'b0 : 1'b1);
    tick(4);
  endtask

  task automatic test_reset();
    tick(2);
    total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL reset_memwrite got=%b exp=0", MemWrite); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", done, err); end
    total++; if (addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", addr); end
    total++; if (din !== 32'h0 || word_count !== 16'h0) begin bad++; $display("FAIL reset_din_wc got=%h/%0d exp=0/0", din, word_count); end
    total++; if (MemRead !== 1'b0 || length !== 2'b10 || sign !== 1'b0) begin bad++; $display("FAIL const_ports got=%b %b %b exp=0 10 0", MemRead, length, sign); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_good_frame();
    int base;
    base = wr_cnt;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy got=%b exp=1", busy); end
    send_frame(8'h2A, -1);
    total++; if (wr_cnt - base !== 2) begin bad++; $display("FAIL good_nwrites got=%0d exp=2", wr_cnt - base); end
    total++; if (wr_addr[base % 32] !== 32'h0 || wr_data[base % 32] !== 32'h12345678) begin bad++; $display("FAIL good_w0 got=%h/%h exp=00000000/12345678", wr_addr[base % 32], wr_data[base % 32]); end
    total++; if (wr_addr[(base + 1) % 32] !== 32'h4 || wr_data[(base + 1) % 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL good_w1 got=%h/%h exp=00000004/deadbeef", wr_addr[(base + 1) % 32], wr_data[(base + 1) % 32]); end
    total++; if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL good_flags got=d%b e%b b%b exp=d1 e0 b0", done, err, busy); end
    total++; if (word_count !== 16'd2) begin bad++; $display("FAIL good_wc got=%0d exp=2", word_count); end
  endtask

  task automatic test_bad_checksum();
    int base;
    base = wr_cnt;
    pulse_start();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL cks_done_cleared got=%b exp=0", done); end
    send_frame(8'h2B, -1);
    total++; if (wr_cnt - base !== 2) begin bad++; $display("FAIL cks_nwrites got=%0d exp=2", wr_cnt - base); end
    total++; if (wr_data[(base + 1) % 32] !== 32'hDEADBEEF) begin bad++; $display("FAIL cks_w1 got=%h exp=deadbeef", wr_data[(base + 1) % 32]); end
    total++; if (err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL cks_flags got=d%b e%b exp=d0 e1", done, err); end
  endtask

  task automatic test_garbage_empty();
    int base;
    logic [7:0] g [6];
    g = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(g[i], 1'b1);
    tick(4);
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL empty_nwrites got=%0d exp=0", wr_cnt - base); end
    total++; if (done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL empty_flags got=d%b e%b exp=d1 e0", done, err); end
    total++; if (word_count !== 16'd0) begin bad++; $display("FAIL empty_wc got=%0d exp=0", word_count); end
  endtask

  task automatic test_oversize();
    int base;
    base = wr_cnt;
    pulse_start();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    total++; if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL oversize_flags got=d%b e%b b%b exp=d0 e1 b0", done, err, busy); end
    total++; if (wr_cnt - base !== 0) begin bad++; $display("FAIL oversize_nwrites got=%0d exp=0", wr_cnt - base); end
  endtask

  task automatic test_framing_error();
    int base;
    base = wr_cnt;
    pulse_start();
    send_frame(8'h2A, 8);
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL ferr_nwrites got=%0d exp=1", wr_cnt - base); end
    total++; if (wr_addr[base % 32] !== 32'h0 || wr_data[base % 32] !== 32'h12345678) begin bad++; $display("FAIL ferr_w0 got=%h/%h exp=00000000/12345678", wr_addr[base % 32], wr_data[base % 32]); end
    total++; if (err !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ferr_flags got=d%b e%b exp=d0 e1", done, err); end
    total++; if (word_count !== 16'd1) begin bad++; $display("FAIL ferr_wc got=%0d exp=1", word_count); end
  endtask

  task automatic test_async_reset();
    logic [7:0] f [7];
    f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(f[i], 1'b1);
    total++; if (busy !== 1'b1 || word_count !== 16'd1) begin bad++; $display("FAIL prerst_state got=b%b wc%0d exp=b1 wc1", busy, word_count); end
    // start bit of the fifth data byte, then reset between clock edges
    uart_rx = 1'b0;
    tick(3 * CPB);
    #2 rst_n = 1'b0;
    #1;
    total++; if (MemWrite !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_mw_busy got=%b%b exp=00", MemWrite, busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL arst_flags got=%b%b exp=00", done, err); end
    total++; if (word_count !== 16'd0 || addr !== 32'h0) begin bad++; $display("FAIL arst_wc_addr got=%0d/%h exp=0/0", word_count, addr); end
    uart_rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3 * CPB);
    test_good_frame();
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    pulse_start();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(150);
    total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL timeout_flags got=e%b b%b exp=e1 b0", err, busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage_empty();
    test_oversize();
    test_framing_error();
    test_async_reset();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
